popcnt_accum: RTL and testbench
===============================

Name: popcnt_accum

Overview:
- Sequential accumulator directly downstream of the 32-bit population-count unit in the ALU path.
- Consumes a stream of 6-bit popcount results (0..32), one per accepted beat, over a programmed burst length.
- Returns the burst total with a valid/ready handshake; the total feeds the ALU result mux for multi-word bit-count and Hamming-distance operations.

Parameters:
- CNT_W, 6, width of incoming popcount value (max legal value 32).
- ACC_W, 16, width of accumulator and result.
- LEN_W, 8, width of burst-length field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a burst, sampled only in IDLE.
- len  input  LEN_W  number of beats in the burst; sampled with start.
- in_valid  input  1  pc_in is valid this cycle.
- in_ready  output  1  accumulator accepts pc_in this cycle.
- pc_in  input  CNT_W  popcount of one 32-bit word from the popcount unit.
- out_valid  output  1  acc_out holds the final burst total.
- out_ready  input  1  consumer accepts the result.
- acc_out  output  ACC_W  burst total.
- sat  output  1  accumulator saturated during this burst.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=0, out_valid=0, acc_out=0, sat=0, busy=0, beat counter=0.
- States: IDLE, RUN, DONE. All outputs are registered, or decoded from the state register only.
- IDLE:
  - start=1 and len!=0: load remaining=len, clear acc_out and sat, go to RUN next cycle.
  - start=1 and len=0: go straight to DONE with acc_out=0, sat=0.
  - start=0: hold state.
- RUN:
  - in_ready=1.
  - A beat is accepted when in_valid and in_ready are both high.
  - Each accepted beat: acc_out <= acc_out + pc_in, computed at ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W-1: acc_out saturates to all-ones and sat sets and stays sticky.
  - Each accepted beat decrements remaining. When the beat with remaining=1 is accepted, go to DONE on the next cycle, with that beat included in acc_out.
  - in_valid low stalls the burst with no state change; there is no timeout.
- DONE:
  - out_valid=1, in_ready=0. acc_out and sat are held stable until the handshake.
  - out_valid && out_ready: go to IDLE next cycle. out_valid drops and acc_out keeps its value until the next start.
- Latency: result visible 1 cycle after the final beat is accepted. Minimum burst of len=1 is start, accept, then out_valid 1 cycle later.
- start outside IDLE is ignored, with no effect on the in-flight burst.
- pc_in values above 32 are out of contract. They are still added arithmetically; no checking is performed.
- rst_n asserted mid-burst aborts immediately to the reset values above. No partial result is emitted.
- Throughput: 1 beat per cycle in RUN. Back-to-back bursts need 1 IDLE cycle between DONE handshake and the next start.

Optional Feature:
- Macro POPACC_MAXTRACK_EN.
- Defined:
  - Adds output max_out (CNT_W bits), reset 0 and cleared on start.
  - max_out tracks the largest pc_in accepted in the current burst and is valid together with out_valid.
  - Also adds output max_idx (LEN_W bits): the zero-based beat index of the first occurrence of that maximum.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_n low 3 cycles, release -> in_ready=0, out_valid=0, acc_out=0, sat=0, busy=0.
- Basic burst: start with len=4, feed pc_in 8,8,32,0 with in_valid held high -> out_valid 1 cycle after 4th accept, acc_out=48, sat=0. With out_ready=1, returns to IDLE next cycle.
- Stall and backpressure: len=3, in_valid toggling 1,0,0,1,0,1 with pc_in=5 on valid beats, out_ready held low 5 cycles -> acc_out=15 held stable, out_valid high until out_ready=1, start pulses during DONE ignored.
- Saturation: ACC_W=8, len=10, pc_in=32 every beat -> acc_out=255, sat=1 from the 8th beat onward; sat cleared by the next start.
- Edge lengths: len=0 -> DONE next cycle with acc_out=0. len=255 with pc_in=1 -> acc_out=255, sat=0.
- Reset mid-burst: len=6, assert rst_n after 3 beats -> all outputs return to reset values asynchronously. A new burst with len=2, pc_in 1,2 gives acc_out=3. With POPACC_MAXTRACK_EN defined, pc_in 4,9,9,2 gives max_out=9, max_idx=1.

Source files
------------

// File: rtl/popcnt_accum.sv
// Burst accumulator for 6-bit popcount results with saturating total and valid/ready result handshake.
// Optional per-burst maximum tracking (max_out/max_idx) is enabled by defining POPACC_MAXTRACK_EN.
module popcnt_accum #(
  parameter int CNT_W = 6,
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat,
  output logic             busy
`ifdef POPACC_MAXTRACK_EN
  ,
  output logic [CNT_W-1:0] max_out,
  output logic [LEN_W-1:0] max_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             accept;
  logic             last_beat;
  logic [ACC_W:0]   sum_wide;

  // One guard bit above the accumulator catches every overflow of a single add.
  function automatic logic [ACC_W:0] wide_add(input logic [ACC_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    return {1'b0, a} + (ACC_W+1)'(b);
  endfunction

  function automatic logic [ACC_W-1:0] sat_clip(input logic [ACC_W:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_ready & in_valid;
  assign last_beat = (remaining == LEN_W'(1));
  assign sum_wide  = wide_add(acc_out, pc_in);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:  if (accept && last_beat) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      acc_out   <= '0;
      sat       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        remaining <= len;
        acc_out   <= '0;
        sat       <= 1'b0;
      end else if (accept) begin
        remaining <= remaining - 1'b1;
        acc_out   <= sat_clip(sum_wide);
        if (sum_wide[ACC_W]) sat <= 1'b1;
      end
    end
  end

`ifdef POPACC_MAXTRACK_EN
  logic [LEN_W-1:0] beat_idx;

  // Strict greater-than keeps the index of the first occurrence of the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
      max_out  <= '0;
      max_idx  <= '0;
    end else if (state == IDLE && start) begin
      beat_idx <= '0;
      max_out  <= '0;
      max_idx  <= '0;
    end else if (accept) begin
      beat_idx <= beat_idx + 1'b1;
      if (pc_in > max_out) begin
        max_out <= pc_in;
        max_idx <= beat_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_popcnt_accum.sv
// Self-checking bench: a 16-bit and an 8-bit accumulator share stimulus; a sum-and-clip model
// predicts totals, sticky saturation, handshake timing and (if POPACC_MAXTRACK_EN) max tracking.
module tb_popcnt_accum;
  localparam int CNT_W = 6;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [CNT_W-1:0] pc_in = '0;
  logic             out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, sat_a, busy_a;
  logic [15:0] acc_a;
  logic        in_ready_b, out_valid_b, sat_b, busy_b;
  logic [7:0]  acc_b;
`ifdef POPACC_MAXTRACK_EN
  logic [CNT_W-1:0] max_a, max_b;
  logic [LEN_W-1:0] idx_a, idx_b;
`endif

  int compared = 0;
  int mismatched = 0;
  int pcq[$];
  int vq[$];
  int rnd_valid = 0;
  int exp_max = 0;
  int exp_idx = 0;

  always #5 clk = ~clk;

  popcnt_accum #(.CNT_W(CNT_W), .ACC_W(16), .LEN_W(LEN_W)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready_a), .pc_in(pc_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .acc_out(acc_a), .sat(sat_a), .busy(busy_a)
`ifdef POPACC_MAXTRACK_EN
    , .max_out(max_a), .max_idx(idx_a)
`endif
  );

  popcnt_accum #(.CNT_W(CNT_W), .ACC_W(8), .LEN_W(LEN_W)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready_b), .pc_in(pc_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .acc_out(acc_b), .sat(sat_b), .busy(busy_b)
`ifdef POPACC_MAXTRACK_EN
    , .max_out(max_b), .max_idx(idx_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Control outputs as {in_ready, out_valid, busy} on both instances.
  task automatic chk_ctl(input string tag, input logic [2:0] exp);
    chk({tag, "/ctl16"}, {29'd0, in_ready_a, out_valid_a, busy_a}, {29'd0, exp});
    chk({tag, "/ctl8"},  {29'd0, in_ready_b, out_valid_b, busy_b}, {29'd0, exp});
  endtask

  task automatic chk_acc(input string tag, input int s);
    chk({tag, "/acc16"}, acc_a, (s > 65535) ? 65535 : s);
    chk({tag, "/sat16"}, sat_a, (s > 65535) ? 1 : 0);
    chk({tag, "/acc8"},  acc_b, (s > 255) ? 255 : s);
    chk({tag, "/sat8"},  sat_b, (s > 255) ? 1 : 0);
  endtask

  task automatic chk_max(input string tag);
`ifdef POPACC_MAXTRACK_EN
    chk({tag, "/max16"}, max_a, exp_max);
    chk({tag, "/idx16"}, idx_a, exp_idx);
    chk({tag, "/max8"},  max_b, exp_max);
    chk({tag, "/idx8"},  idx_b, exp_idx);
`endif
  endtask

  // Runs one burst of n beats; pc values come from pcq (else random 0..32),
  // valid pattern from vq (else random or always-on); result held for `hold` cycles.
  task automatic burst(input string tag, input int n, input int hold);
    int sum = 0;
    int cnt = 0;
    int cyc = 0;
    int v, p;
    exp_max = 0;
    exp_idx = 0;
    @(negedge clk);
    chk_ctl({tag, "/idle"}, 3'b000);
    start = 1'b1;
    len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    while (cnt < n && cyc < 2000) begin
      chk_ctl({tag, "/run"}, 3'b101);
      chk_acc({tag, "/run"}, sum);
      if (vq.size() > 0) v = vq.pop_front();
      else v = rnd_valid ? int'($urandom_range(0, 1)) : 1;
      if (v != 0) p = (pcq.size() > 0) ? pcq.pop_front() : int'($urandom_range(0, 32));
      else p = int'($urandom_range(0, 63));
      in_valid = (v != 0);
      pc_in = CNT_W'(p);
      start = ($urandom_range(0, 3) == 0);
      len = LEN_W'($urandom_range(0, 255));
      @(negedge clk);
      if (v != 0) begin
        if (p > exp_max) begin
          exp_max = p;
          exp_idx = cnt;
        end
        sum += p;
        cnt++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk({tag, "/beats_done"}, cnt, n);
    for (int k = 0; k <= hold; k++) begin
      chk_ctl({tag, "/done"}, 3'b011);
      chk_acc({tag, "/done"}, sum);
      chk_max({tag, "/done"});
      if (k < hold) begin
        start = $urandom_range(0, 1) ? 1'b1 : 1'b0;
        len = LEN_W'($urandom_range(0, 255));
        @(negedge clk);
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_ctl({tag, "/after"}, 3'b000);
    chk_acc({tag, "/after"}, sum);
  endtask

  initial begin
    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_ctl("rst_hold", 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    chk_ctl("rst_idle", 3'b000);
    chk_acc("rst_idle", 0);
    chk_max("rst_idle");

    pcq = '{8, 8, 32, 0};
    burst("basic", 4, 0);

    vq = '{1, 0, 0, 1, 0, 1};
    pcq = '{5, 5, 5};
    burst("stall", 3, 5);

    pcq = '{32, 32, 32, 32, 32, 32, 32, 32, 32, 32};
    burst("satur", 10, 1);

    burst("len0", 0, 2);

    for (int i = 0; i < 255; i++) pcq.push_back(1);
    burst("len255", 255, 0);

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    start = 1'b1;
    len = 8'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      in_valid = 1'b1;
      pc_in = CNT_W'($urandom_range(1, 32));
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("midrst", 3'b000);
    chk_acc("midrst", 0);
    chk_max("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    pcq = '{1, 2};
    burst("post_rst", 2, 0);

    pcq = '{4, 9, 9, 2};
    burst("maxtrk", 4, 1);

    pcq = '{63, 63, 63, 63, 63};
    burst("oob_pc", 5, 0);

    rnd_valid = 1;
    for (int i = 0; i < 8; i++) burst("random", int'($urandom_range(1, 40)), int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
